// File: rtl/quan_cbr_pkg.sv
// Shared types and constants for the quantised CBR tile scheduler.
package quan_cbr_pkg;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } sched_state_e;

  // Cycles the kernel controller is held in reset while it loads its init values
  localparam int unsigned CTRL_RST_CYCLES = 2;
  // Minimum cycles from tile_end to the next launch; WAIT + ISSUE give exactly this
  localparam int unsigned MIN_TILE_GAP    = 2;
  // Output channels produced per tile by the systolic array
  localparam int unsigned SA_ROWS         = 32;

  localparam int unsigned MODE_W = 4;
  localparam int unsigned NIF_W  = 32;

  // Per-layer configuration handed to the kernel controller
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [NIF_W-1:0]  nif;
  } layer_cfg_t;

endpackage

// File: rtl/quan_cbr_watchdog.sv
// Cycle watchdog: clears on request, counts while enabled, flags the terminal count.
module quan_cbr_watchdog #(
  parameter int unsigned TO_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES = 32'h000F_FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit_c
);

  // Hit fires in the cycle whose increment would bring the count to TIMEOUT_CYCLES
  localparam logic [TO_W-1:0] TERM  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit              WD_ON = (TIMEOUT_CYCLES != 0);

  logic [TO_W-1:0] r_count;

  // Cycle counter with priority clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign o_hit_c = WD_ON && i_en && (r_count == TERM);

endmodule

// File: rtl/quan_cbr_tile_scheduler.sv
// Layer-level tile sequencer for the quantised CBR kernel controller.
module quan_cbr_tile_scheduler
  import quan_cbr_pkg::*;
#(
  parameter int unsigned TILE_W         = 16,
  parameter int unsigned TO_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES = 32'h000F_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        mode_cfg,
  input  logic [31:0]       nif_mult_k_mult_k_cfg,
  input  logic [TILE_W-1:0] tile_num,
  input  logic              fm_ready,
  input  logic              out_space_ok,
  input  logic              tile_end,
  output logic              ctrl_reset,
  output logic [3:0]        mode_init,
  output logic [31:0]       nif_mult_k_mult_k_init,
  output logic              re_fm_en,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = (CTRL_RST_CYCLES > 2) ? $clog2(CTRL_RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CTRL_RST_CYCLES - 1);

  sched_state_e      r_state;
  layer_cfg_t        r_cfg;
  logic [TILE_W-1:0] r_tile_num;
  logic [TILE_W-1:0] r_tile_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ctrl_reset;
  logic              r_re_fm_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_hit;
  logic [TILE_W-1:0] w_idx_nxt;
  logic              w_abort_req;

  assign w_wd_clr    = (r_state == ST_ISSUE);
  assign w_wd_en     = (r_state == ST_RUN);
  assign w_idx_nxt   = r_tile_idx + TILE_W'(1);
  assign w_abort_req = (r_state != ST_IDLE) && (r_state != ST_ABORT) && (abort || w_wd_hit);

  quan_cbr_watchdog #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_wd_clr),
    .i_en    (w_wd_en),
    .o_hit_c (w_wd_hit)
  );

  // Scheduler FSM with registered outputs; abort/timeout outrank tile_end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cfg        <= '0;
      r_tile_num   <= '0;
      r_tile_idx   <= '0;
      r_cnt        <= '0;
      r_ctrl_reset <= 1'b1;
      r_re_fm_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_re_fm_en <= 1'b0;
      r_done     <= 1'b0;
      if (w_abort_req) begin
        r_state      <= ST_ABORT;
        r_ctrl_reset <= 1'b1;
        r_cnt        <= '0;
        if (w_wd_hit) begin
          r_err <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ctrl_reset <= 1'b0;
            if (start) begin
              r_state      <= ST_CFG;
              r_ctrl_reset <= 1'b1;
              r_busy       <= 1'b1;
              r_cnt        <= '0;
              r_cfg.mode   <= mode_cfg;
              r_cfg.nif    <= nif_mult_k_mult_k_cfg;
              r_tile_num   <= tile_num;
              r_tile_idx   <= '0;
              r_err        <= 1'b0;
            end
          end
          ST_CFG: begin
            if (r_cnt == CNT_LAST) begin
              r_ctrl_reset <= 1'b0;
              if (r_tile_num == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (fm_ready && out_space_ok) begin
              r_state    <= ST_ISSUE;
              r_re_fm_en <= 1'b1;
            end
          end
          ST_ISSUE: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (tile_end) begin
              r_tile_idx <= w_idx_nxt;
              if (w_idx_nxt == r_tile_num) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          ST_ABORT: begin
            if (r_cnt == CNT_LAST) begin
              r_state      <= ST_IDLE;
              r_ctrl_reset <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_ctrl_reset <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_reset             = r_ctrl_reset;
  assign mode_init              = r_cfg.mode;
  assign nif_mult_k_mult_k_init = r_cfg.nif;
  assign re_fm_en               = r_re_fm_en;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign tile_idx               = r_tile_idx;
  assign err_timeout            = r_err;

endmodule

// File: tb/tb_quan_cbr_tile_scheduler.sv
// Self-checking bench for quan_cbr_tile_scheduler: layer table plus corner-case sequences.
module tb_quan_cbr_tile_scheduler;

  localparam int unsigned TILE_W = 16;
  localparam int unsigned BUDGET = 400;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [3:0]        mode_cfg;
  logic [31:0]       nif_cfg;
  logic [TILE_W-1:0] tile_num;
  logic              fm_ready;
  logic              out_space_ok;
  logic              tile_end;
  logic              ctrl_reset;
  logic [3:0]        mode_init;
  logic [31:0]       nif_init;
  logic              re_fm_en;
  logic              busy;
  logic              done;
  logic [TILE_W-1:0] tile_idx;
  logic              err_timeout;

  int checks = 0;
  int errors = 0;

  quan_cbr_tile_scheduler #(
    .TILE_W         (TILE_W),
    .TO_W           (20),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .abort                  (abort),
    .mode_cfg               (mode_cfg),
    .nif_mult_k_mult_k_cfg  (nif_cfg),
    .tile_num               (tile_num),
    .fm_ready               (fm_ready),
    .out_space_ok           (out_space_ok),
    .tile_end               (tile_end),
    .ctrl_reset             (ctrl_reset),
    .mode_init              (mode_init),
    .nif_mult_k_mult_k_init (nif_init),
    .re_fm_en               (re_fm_en),
    .busy                   (busy),
    .done                   (done),
    .tile_idx               (tile_idx),
    .err_timeout            (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard of expected launch/done events with the tile index each must carry
  typedef struct {
    logic              is_done;
    logic [TILE_W-1:0] idx;
  } ev_t;

  ev_t sb_q[$];

  task automatic sb_push(input logic is_done, input logic [TILE_W-1:0] idx);
    ev_t e;
    e.is_done = is_done;
    e.idx     = idx;
    sb_q.push_back(e);
  endtask

  // Event monitor: every re_fm_en / done pulse consumes one expected event
  always @(negedge clk) begin
    if (!reset && (re_fm_en || done)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_event", {30'd0, done, re_fm_en}, 32'd0);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        check("sb_event_kind", {31'd0, done}, {31'd0, e.is_done});
        check("sb_event_idx", 32'(tile_idx), 32'(e.idx));
      end
    end
  end

  // One layer run: config, tile_end spacing, readiness dropout window, expectations
  typedef struct {
    logic [3:0]        mode;
    logic [31:0]       nif;
    logic [TILE_W-1:0] tnum;
    int                gap;
    bit                bp_fm;
    int                bp_start;
    int                bp_len;
    int                exp_launches;
    int                exp_done_cyc;
  } vec_t;

  task automatic run_layer(input vec_t v);
    int   launches;
    int   done_cyc;
    int   crst_cyc;
    int   te_at;
    logic prev_rdy;
    logic in_bp;
    launches = 0;
    done_cyc = -1;
    crst_cyc = 0;
    te_at    = -1;
    prev_rdy = 1'b0;
    for (int j = 0; j < int'(v.tnum); j++) sb_push(1'b0, TILE_W'(j));
    sb_push(1'b1, v.tnum);
    mode_cfg = v.mode;
    nif_cfg  = v.nif;
    tile_num = v.tnum;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("cfg_mode_init", 32'(mode_init), 32'(v.mode));
    check("cfg_nif_init", nif_init, v.nif);
    check("cfg_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(BUDGET); i++) begin
      if (ctrl_reset) crst_cyc++;
      if (i < 3) check("cfg_ctrl_reset_window", {31'd0, ctrl_reset}, (i < 2) ? 32'd1 : 32'd0);
      if (re_fm_en) begin
        launches++;
        check("launch_after_ready", {31'd0, prev_rdy}, 32'd1);
        te_at = i + v.gap;
      end
      if (done) begin
        done_cyc = i;
        break;
      end
      tile_end     = (i == te_at);
      in_bp        = (v.bp_len > 0) && (i >= v.bp_start) && (i < v.bp_start + v.bp_len);
      fm_ready     = !(in_bp && v.bp_fm);
      out_space_ok = !(in_bp && !v.bp_fm);
      prev_rdy     = fm_ready && out_space_ok;
      tick();
    end
    tile_end     = 1'b0;
    fm_ready     = 1'b1;
    out_space_ok = 1'b1;
    check("layer_launch_count", 32'(launches), 32'(v.exp_launches));
    check("layer_done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
    check("layer_ctrl_reset_cycles", 32'(crst_cyc), 32'd2);
    tick();
    check("layer_busy_after", {31'd0, busy}, 32'd0);
    check("layer_done_width", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int   launch_i;
    int   n_launch;
    bit   seen_done;

    // mode, nif, tnum, gap, bp_fm, bp_start, bp_len, exp_launches, exp_done_cyc
    vecs[0] = '{4'd1,  32'd17,          16'd3, 60, 1'b0, 0,  0,  3, 188};
    vecs[1] = '{4'd2,  32'd5,           16'd0, 1,  1'b0, 0,  0,  0, 2};
    vecs[2] = '{4'hF,  32'hDEAD_BEEF,   16'd1, 5,  1'b0, 0,  0,  1, 9};
    vecs[3] = '{4'd3,  32'd99,          16'd2, 1,  1'b0, 0,  0,  2, 8};
    vecs[4] = '{4'd6,  32'd40,          16'd3, 10, 1'b0, 24, 10, 3, 46};
    vecs[5] = '{4'd7,  32'd41,          16'd2, 4,  1'b1, 0,  10, 2, 22};

    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    mode_cfg     = '0;
    nif_cfg      = '0;
    tile_num     = '0;
    fm_ready     = 1'b1;
    out_space_ok = 1'b1;
    tile_end     = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl_reset", {31'd0, ctrl_reset}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_re_fm_en", {31'd0, re_fm_en}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tile_idx", 32'(tile_idx), 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_mode_init", 32'(mode_init), 32'd0);
    check("rst_nif_init", nif_init, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("idle_ctrl_reset", {31'd0, ctrl_reset}, 32'd0);

    foreach (vecs[k]) run_layer(vecs[k]);

    // tile_end in IDLE leaves the final index alone
    tile_end = 1'b1;
    tick();
    tile_end = 1'b0;
    tick();
    check("idle_tile_end_ignored", 32'(tile_idx), 32'd2);

    // Watchdog: tile_end withheld after the first launch
    sb_push(1'b0, '0);
    mode_cfg = 4'd2;
    nif_cfg  = 32'd8;
    tile_num = 16'd2;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    launch_i  = -1;
    seen_done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (re_fm_en && launch_i < 0) launch_i = i;
      if (done) seen_done = 1'b1;
      if (i == 103) check("wd_err_before", {31'd0, err_timeout}, 32'd0);
      if (i == 104) begin
        check("wd_err_set", {31'd0, err_timeout}, 32'd1);
        check("wd_ctrl_reset_1", {31'd0, ctrl_reset}, 32'd1);
        check("wd_busy_abort", {31'd0, busy}, 32'd1);
      end
      if (i == 105) check("wd_ctrl_reset_2", {31'd0, ctrl_reset}, 32'd1);
      if (i == 106) begin
        check("wd_ctrl_reset_off", {31'd0, ctrl_reset}, 32'd0);
        check("wd_idle", {31'd0, busy}, 32'd0);
      end
      tick();
    end
    check("wd_launch_cycle", 32'(launch_i), 32'd3);
    check("wd_no_done", {31'd0, seen_done}, 32'd0);
    check("wd_tile_idx", 32'(tile_idx), 32'd0);
    check("wd_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Abort coincident with tile_end; start during ABORT ignored
    sb_push(1'b0, 16'd0);
    sb_push(1'b0, 16'd1);
    mode_cfg = 4'd5;
    nif_cfg  = 32'd3;
    tile_num = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", {31'd0, err_timeout}, 32'd0);
    n_launch  = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (re_fm_en) n_launch++;
      if (done) seen_done = 1'b1;
      if (i == 22) begin
        check("ab_tile_idx_frozen", 32'(tile_idx), 32'd1);
        check("ab_ctrl_reset_1", {31'd0, ctrl_reset}, 32'd1);
      end
      if (i == 23) check("ab_ctrl_reset_2", {31'd0, ctrl_reset}, 32'd1);
      if (i == 24) begin
        check("ab_ctrl_reset_off", {31'd0, ctrl_reset}, 32'd0);
        check("ab_idle", {31'd0, busy}, 32'd0);
      end
      if (i == 30) check("ab_start_ignored", {31'd0, busy}, 32'd0);
      tile_end = (i == 11) || (i == 21);
      abort    = (i == 21);
      start    = (i == 22);
      tick();
    end
    tile_end = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    check("ab_launch_count", 32'(n_launch), 32'd2);
    check("ab_no_done", {31'd0, seen_done}, 32'd0);
    check("ab_tile_idx_final", 32'(tile_idx), 32'd1);
    check("ab_err_clear", {31'd0, err_timeout}, 32'd0);

    // Asynchronous reset in the middle of RUN
    sb_push(1'b0, 16'd0);
    sb_push(1'b0, 16'd1);
    tile_num = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tile_end = (i == 8);
      tick();
    end
    tile_end = 1'b0;
    check("ar_pre_tile_idx", 32'(tile_idx), 32'd1);
    check("ar_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_re_fm_en", {31'd0, re_fm_en}, 32'd0);
    check("ar_tile_idx", 32'(tile_idx), 32'd0);
    check("ar_ctrl_reset", {31'd0, ctrl_reset}, 32'd1);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("ar_release_ctrl_reset", {31'd0, ctrl_reset}, 32'd0);
    check("ar_release_busy", {31'd0, busy}, 32'd0);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
